// File: rtl/ring_fifo_tx.sv
// Transactional ring buffer with private synchronous-read storage.
// Pushes inside an open transaction stay hidden from pop until commit; overflow either evicts or rejects.
module ring_fifo_tx #(
  parameter int DATA_W   = 16,
  parameter int DEPTH    = 256,
  parameter int OVF_MODE = 0,
  localparam int CNT_W   = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              open,
  input  logic              commit,
  input  logic              rollback,
  input  logic              push_valid,
  input  logic [DATA_W-1:0] push_data,
  output logic              push_ready,
  input  logic              pop_req,
  output logic              pop_valid,
  output logic [DATA_W-1:0] pop_data,
  output logic [CNT_W-1:0]  used,
  output logic [CNT_W-1:0]  pending,
  output logic              in_tx,
  output logic              dropped,
  output logic [15:0]       drop_cnt
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [CNT_W:0]   FULL_LVL = (CNT_W + 1)'(DEPTH);
  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);
  localparam logic [PTR_W-1:0] LAST     = PTR_W'(DEPTH - 1);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rd_q;

  logic [PTR_W-1:0] rd_ptr, tx_ptr, wr_ptr;
  logic [PTR_W-1:0] rd_n, tx_n, wr_n, wr_inc;
  logic [CNT_W-1:0] used_n, pend_n, push_one;
  logic [CNT_W:0]   fill;
  logic             full, rb, cm, pop_acc, push_take, ovf, reject;
  logic             in_tx_n, pop_pend;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST) ? '0 : p + PTR_W'(1);
  endfunction

  assign fill       = {1'b0, used} + {1'b0, pending};
  assign full       = (fill == FULL_LVL);
  assign push_ready = (OVF_MODE == 1) ? ~full : 1'b1;

  assign rb        = rollback & in_tx;
  assign cm        = commit & in_tx & ~rb;
  assign pop_acc   = pop_req & (used != '0);
  assign push_take = push_valid & push_ready & ~rb;
  // A pop accepted this cycle frees the slot, so a push at full only evicts without one.
  assign ovf       = push_take & full & ~pop_acc;
  assign reject    = push_valid & ~push_ready;
  assign push_one  = {{(CNT_W-1){1'b0}}, push_take};
  assign wr_inc    = push_take ? ptr_inc(wr_ptr) : wr_ptr;

  always_comb begin
    rd_n    = rd_ptr;
    tx_n    = tx_ptr;
    wr_n    = wr_ptr;
    used_n  = used;
    pend_n  = pending;
    in_tx_n = in_tx;

    if (pop_acc) begin
      rd_n   = ptr_inc(rd_ptr);
      used_n = used - ONE;
    end

    // Eviction prefers committed data; only an all-pending buffer loses a pending word.
    if (ovf) begin
      rd_n = ptr_inc(rd_ptr);
      if (used != '0) begin
        used_n = used - ONE;
      end else begin
        tx_n   = ptr_inc(tx_ptr);
        pend_n = pending - ONE;
      end
    end

    if (rb) begin
      wr_n    = tx_n;
      pend_n  = '0;
      in_tx_n = open;
    end else if (open) begin
      // Implicit commit of the old transaction; a same-cycle push starts the new one.
      used_n  = used_n + pend_n;
      pend_n  = push_one;
      tx_n    = wr_ptr;
      wr_n    = wr_inc;
      in_tx_n = 1'b1;
    end else if (cm || !in_tx) begin
      used_n  = used_n + pend_n + push_one;
      pend_n  = '0;
      tx_n    = wr_inc;
      wr_n    = wr_inc;
      in_tx_n = 1'b0;
    end else begin
      pend_n = pend_n + push_one;
      wr_n   = wr_inc;
    end
  end

  // Read-first RAM: a pop at full reads the old word even though the push targets the same slot.
  always_ff @(posedge clk) begin
    if (push_take) mem[wr_ptr] <= push_data;
    if (pop_acc)   rd_q <= mem[rd_ptr];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr    <= '0;
      tx_ptr    <= '0;
      wr_ptr    <= '0;
      used      <= '0;
      pending   <= '0;
      in_tx     <= 1'b0;
      pop_pend  <= 1'b0;
      pop_valid <= 1'b0;
      pop_data  <= '0;
      dropped   <= 1'b0;
      drop_cnt  <= '0;
    end else begin
      rd_ptr    <= rd_n;
      tx_ptr    <= tx_n;
      wr_ptr    <= wr_n;
      used      <= used_n;
      pending   <= pend_n;
      in_tx     <= in_tx_n;
      pop_pend  <= pop_acc;
      pop_valid <= pop_pend;
      if (pop_pend) pop_data <= rd_q;
      dropped   <= ovf | reject;
      if ((ovf | reject) && (drop_cnt != 16'hFFFF)) drop_cnt <= drop_cnt + 16'd1;
    end
  end

endmodule
